// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared state and next-PC source encodings for the fetch PC unit
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_REDIR,
    SEL_RAS,
    SEL_SEQ,
    SEL_HOLD
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a full stack overwrites its oldest entry
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   count;
  logic            replace;
  logic [PW-1:0]   wr_idx;

  // push+pop on a non-empty stack swaps the top in place; on an empty one it is a plain push
  always_comb begin
    replace = push && pop && (count != '0);
    wr_idx  = replace ? ptr : ptr + PTR_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && !replace) begin
      ptr <= ptr + PTR_ONE;
      if (count != CNT_MAX) count <= count + CNT_ONE;
    end else if (pop && !push && (count != '0)) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_data;
  end

  assign top   = mem[ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with trap/redirect/RAS/sequential next-PC selection
module pc_unit
  import pc_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misaligned,
  output logic            ras_empty
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INC - 1);
  localparam logic [XLEN-1:0] INC_V    = XLEN'(INC);

  pc_state_e       state;
  pc_sel_e         sel;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  logic            take_trap;
  logic            take_redir;
  logic            ras_ops;
  logic            go_halt;

  // HALTED ignores enable for exits; RUN honours enable only for redirects
  always_comb begin
    seq_pc     = pc_out + INC_V;
    take_trap  = trap_valid && (state != ST_BOOT);
    take_redir = redirect_valid && ((state == ST_HALTED) || (state == ST_RUN && enable));
    target     = take_trap ? trap_vector : redirect_target;
    go_halt    = (state == ST_RUN) && enable && halt && !trap_valid && !redirect_valid;
    ras_ops    = (state == ST_RUN) && enable && !trap_valid && !redirect_valid && !halt;

    if (take_trap)                       sel = SEL_TRAP;
    else if (take_redir)                 sel = SEL_REDIR;
    else if (ras_ops && ret && !ras_empty) sel = SEL_RAS;
    else if (ras_ops)                    sel = SEL_SEQ;
    else                                 sel = SEL_HOLD;

    case (sel)
      SEL_TRAP, SEL_REDIR: next_pc = target & ~LOW_MASK;
      SEL_RAS:             next_pc = ras_top;
      SEL_SEQ:             next_pc = seq_pc;
      default:             next_pc = pc_out;
    endcase
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_ops && call),
    .pop       (ras_ops && ret),
    .push_data (seq_pc),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_BOOT;
      pc_out     <= RESET_VECTOR;
      pc_valid   <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      pc_out     <= next_pc;
      misaligned <= ((sel == SEL_TRAP) || (sel == SEL_REDIR)) && ((target & LOW_MASK) != '0);
      case (state)
        ST_BOOT: begin
          state    <= ST_RUN;
          pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (go_halt) begin
            state    <= ST_HALTED;
            pc_valid <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (take_trap || take_redir) begin
            state    <= ST_RUN;
            pc_valid <= 1'b1;
          end
        end
        default: begin
          state    <= ST_BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed and randomized bench for pc_unit against a queue-based reference model
module tb_pc_unit;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int          INC   = 4;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0, halt = 1'b0, redirect_valid = 1'b0, trap_valid = 1'b0;
  logic        call = 1'b0, ret = 1'b0;
  logic [31:0] redirect_target = '0, trap_vector = '0;
  logic [31:0] pc_out;
  logic        pc_valid, misaligned, ras_empty;

  int vectors = 0;
  int miscompares = 0;

  // reference model: 0 = boot, 1 = run, 2 = halted; RAS as a queue, newest at the back
  int          m_state;
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] ras[$];

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .INC          (INC),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .call            (call),
    .ret             (ret),
    .pc_out          (pc_out),
    .pc_valid        (pc_valid),
    .misaligned      (misaligned),
    .ras_empty       (ras_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = RV;
    m_mis   = 1'b0;
    ras.delete();
  endtask

  task automatic model_load(input logic [31:0] t);
    m_pc  = t - (t % INC);
    m_mis = (t % INC) != 0;
  endtask

  task automatic model_step();
    logic [31:0] seq, nxt;
    if (!reset) begin
      model_reset();
      return;
    end
    m_mis = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 2) begin
      if (trap_valid) begin model_load(trap_vector); m_state = 1; end
      else if (redirect_valid) begin model_load(redirect_target); m_state = 1; end
    end else begin
      if (trap_valid) model_load(trap_vector);
      else if (!enable) begin end
      else if (redirect_valid) model_load(redirect_target);
      else if (halt) m_state = 2;
      else begin
        seq = m_pc + INC;
        if (ret && ras.size() > 0) begin
          nxt = ras[ras.size()-1];
          if (call) ras[ras.size()-1] = seq;
          else void'(ras.pop_back());
        end else begin
          nxt = seq;
          if (call) begin
            ras.push_back(seq);
            if (ras.size() > DEPTH) void'(ras.pop_front());
          end
        end
        m_pc = nxt;
      end
    end
  endtask

  task automatic check_model();
    check("pc_out", pc_out, m_pc);
    check("pc_valid", {31'b0, pc_valid}, {31'b0, m_state == 1});
    check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    check("ras_empty", {31'b0, ras_empty}, {31'b0, ras.size() == 0});
  endtask

  task automatic drive(input logic en, input logic h, input logic rv, input logic [31:0] rt,
                       input logic tv, input logic [31:0] tt, input logic c, input logic r);
    enable = en; halt = h; redirect_valid = rv; redirect_target = rt;
    trap_valid = tv; trap_vector = tt; call = c; ret = r;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1 check_model();
  endtask

  task automatic mid_reset();
    #3 reset = 1'b0;
    model_reset();
    #1 check_model();
    check("rst_pc", pc_out, RV);
    #1 reset = 1'b1;
  endtask

  logic [31:0] ret_exp [4];

  initial begin
    model_reset();
    #2 check_model();
    check("por_pc", pc_out, RV);
    cycle();
    cycle();
    reset = 1'b1;

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(); check("boot_pc", pc_out, 32'h0); check("boot_valid", {31'b0, pc_valid}, 32'h1);
    cycle(); check("seq1", pc_out, 32'h4);
    cycle(); check("seq2", pc_out, 32'h8);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle(); check("stall_hold", pc_out, 32'h8);
    drive(0, 0, 1, 32'h100, 0, 0, 0, 0);
    cycle(); check("stall_redir", pc_out, 32'h8);
    drive(0, 0, 0, 0, 1, 32'h200, 0, 0);
    cycle(); check("stall_trap", pc_out, 32'h200);

    drive(1, 0, 1, 32'h1003, 1, 32'h300, 0, 0);
    cycle(); check("trap_prio", pc_out, 32'h300); check("trap_mis", {31'b0, misaligned}, 32'h0);
    drive(1, 0, 1, 32'h1003, 0, 0, 0, 0);
    cycle(); check("redir_align", pc_out, 32'h1000); check("redir_mis", {31'b0, misaligned}, 32'h1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(); check("mis_clear", {31'b0, misaligned}, 32'h0);

    for (int k = 1; k <= 5; k++) begin
      drive(1, 0, 1, 32'(k * 16), 0, 0, 0, 0);
      cycle();
      drive(1, 0, 0, 0, 0, 0, 1, 0);
      cycle(); check("call_seq", pc_out, 32'(k * 16 + 4));
    end
    ret_exp[0] = 32'h54; ret_exp[1] = 32'h44; ret_exp[2] = 32'h34; ret_exp[3] = 32'h24;
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cycle(); check("ret_target", pc_out, ret_exp[k]);
    end
    cycle(); check("ret_empty_seq", pc_out, 32'h28); check("ras_empty", {31'b0, ras_empty}, 32'h1);

    drive(1, 0, 1, 32'h40, 0, 0, 0, 0);
    cycle();
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(); check("halt_pc", pc_out, 32'h40); check("halt_valid", {31'b0, pc_valid}, 32'h0);
    drive(1, 1, 0, 0, 0, 0, 1, 1);
    cycle(); check("halted_hold", pc_out, 32'h40);
    drive(0, 0, 1, 32'h80, 0, 0, 0, 0);
    cycle(); check("unhalt_pc", pc_out, 32'h80); check("unhalt_valid", {31'b0, pc_valid}, 32'h1);

    drive(1, 0, 0, 0, 0, 0, 1, 0);
    cycle(); cycle(); check("two_calls", {31'b0, ras_empty}, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    mid_reset();
    check("rst_empty", {31'b0, ras_empty}, 32'h1);
    check("rst_valid", {31'b0, pc_valid}, 32'h0);
    cycle();

    drive(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(); check("wrap", pc_out, 32'h0);

    for (int n = 0; n < 500; n++) begin
      logic [31:0] rt, tt;
      rt = $urandom; tt = $urandom;
      if ($urandom_range(1) == 0) rt[1:0] = 2'b00;
      if ($urandom_range(1) == 0) tt[1:0] = 2'b00;
      drive($urandom_range(9) != 0, $urandom_range(19) == 0, $urandom_range(7) == 0, rt,
            $urandom_range(15) == 0, tt, $urandom_range(3) == 0, $urandom_range(3) == 0);
      if ($urandom_range(149) == 0) mid_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
